serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inStart  input  1  request to begin a comparison.
REQ-005 inA  input  WIDTH  operand A, unsigned.
REQ-006 inB  input  WIDTH  operand B, unsigned.
REQ-007 outBusy  output  1  high while a comparison is in progress.
REQ-008 outDone  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 outGT  output  1  A > B.
REQ-010 outEQ  output  1  A == B.
REQ-011 outLT  output  1  A < B.

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
- IDLE->BUSY: inStart=1.
- BUSY->DONE: final slice consumed.
- DONE->IDLE: unconditional, after one cycle.
REQ-013 inStart SHALL be accepted only in IDLE; on acceptance, inA and inB SHALL be latched into internal registers.
- Later changes to inA and inB SHALL NOT affect the comparison in progress.
REQ-014 In BUSY, each rising edge SHALL consume one 2-bit slice of each latched operand, MSB pair first (bits [WIDTH-1:WIDTH-2], then [WIDTH-3:WIDTH-4], and so on).
- Each slice SHALL be classified as greater, equal or less as a 2-bit unsigned magnitude compare.
REQ-015 The result SHALL be decided by the first unequal slice, most significant first.
- If all slices are equal, outEQ SHALL be 1.
REQ-016 outBusy SHALL be 1 exactly in BUSY; outDone SHALL be 1 exactly in DONE.
REQ-017 Latency: with the acceptance edge as e0, outDone SHALL assert in the cycle following edge e(WIDTH/2).
- outBusy SHALL be high for WIDTH/2 cycles.
- Exception: early exit, per REQ-024.
REQ-018 outGT, outEQ and outLT SHALL be registered, and SHALL change only on the edge entering DONE.
- From DONE onward, exactly one SHALL be 1.
- The values SHALL hold through IDLE until the next comparison completes.
REQ-019 inStart asserted in BUSY or DONE SHALL be ignored; it is neither queued nor allowed to restart the comparison.
REQ-020 If inStart is held high continuously, a new comparison SHALL be accepted in the first IDLE cycle after DONE.
- This gives back-to-back throughput of one result per WIDTH/2+2 cycles.

Reset
REQ-021 reset=1 at a rising edge SHALL force IDLE from any state, including mid-BUSY, and abort any comparison in progress.
REQ-022 After reset: outBusy=0, outDone=0, outGT=0, outEQ=0, outLT=0, and the latched operands and slice counter SHALL be 0.
REQ-023 reset SHALL take priority over inStart in the same cycle.

Configuration
REQ-024 Macro SERIAL_COMPARATOR_EARLY_EXIT_EN:
- Defined: BUSY SHALL transition to DONE on the edge consuming the first unequal slice.
  - If that slice is slice j (1-based), outDone SHALL assert in the cycle after edge ej.
  - An all-equal comparison still takes WIDTH/2 cycles.
- Undefined: every comparison SHALL take exactly WIDTH/2 BUSY cycles, regardless of data.
- Result values SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-025 inA=8'hA5, inB=8'hA5, inStart pulse -> outDone in the cycle after e4; outEQ=1, outGT=0, outLT=0; outBusy high for 4 cycles.
REQ-026 inA=8'h80, inB=8'h7F -> outGT=1; outDone after e1 if SERIAL_COMPARATOR_EARLY_EXIT_EN is defined, otherwise after e4.
REQ-027 inA=8'h12, inB=8'h13 -> outLT=1 after e4 in both builds, since the last slice decides.
REQ-028 Start accepted with inA=8'hFF, inB=8'h00; at e1 drive inA=8'h00 and pulse inStart again -> outGT=1 from a single comparison, and no second comparison starts.
REQ-029 reset=1 at e2 of a comparison -> IDLE next cycle; all outputs 0; no outDone pulse. A subsequent start with inA=8'h03, inB=8'h02 -> outGT=1.
REQ-030 inStart held high for 20 cycles, operands constant -> outDone pulses periodically.
- Without the macro: every 6 cycles.
- Results stable between pulses.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: unsigned A/B magnitude compare, one 2-bit slice per cycle, MSB first.
// Define SERIAL_COMPARATOR_EARLY_EXIT_EN to finish on the first unequal slice.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inStart,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             outBusy,
  output logic             outDone,
  output logic             outGT,
  output logic             outEQ,
  output logic             outLT
);
  localparam int N  = WIDTH / 2;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [CW-1:0]    cnt;
  logic             res_gt, res_lt;
  logic [1:0]       sa, sb;
  logic             dgt, dlt, last, fin;
  assign sa   = a[WIDTH-1 -: 2];
  assign sb   = b[WIDTH-1 -: 2];
  // an earlier (more significant) unequal slice always wins
  assign dgt  = res_gt | (~res_lt & (sa > sb));
  assign dlt  = res_lt | (~res_gt & (sa < sb));
  assign last = cnt == CW'(N - 1);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign fin  = last | dgt | dlt;
`else
  assign fin  = last;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      cnt     <= '0;
      res_gt  <= 1'b0;
      res_lt  <= 1'b0;
      outBusy <= 1'b0;
      outDone <= 1'b0;
      outGT   <= 1'b0;
      outEQ   <= 1'b0;
      outLT   <= 1'b0;
    end else if (state == IDLE) begin
      if (inStart) begin
        state   <= BUSY;
        a       <= inA;
        b       <= inB;
        cnt     <= '0;
        res_gt  <= 1'b0;
        res_lt  <= 1'b0;
        outBusy <= 1'b1;
      end
    end else if (state == BUSY) begin
      a      <= a << 2;
      b      <= b << 2;
      cnt    <= cnt + CW'(1);
      res_gt <= dgt;
      res_lt <= dlt;
      if (fin) begin
        state   <= DONE;
        outBusy <= 1'b0;
        outDone <= 1'b1;
        outGT   <= dgt;
        outLT   <= dlt;
        outEQ   <= ~(dgt | dlt);
      end
    end else begin
      state   <= IDLE;
      outDone <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed vectors for serial_comparator at WIDTH=8.
module tb_serial_comparator;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inStart = 1'b0;
  logic [7:0] inA = '0;
  logic [7:0] inB = '0;
  logic       outBusy, outDone, outGT, outEQ, outLT;
  int         vectors = 0;
  int         miss = 0;
  int         lat, busy_n, pulses, seen;
  int         idx[$];
  bit         stable;

  serial_comparator #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inStart(inStart), .inA(inA), .inB(inB),
    .outBusy(outBusy), .outDone(outDone), .outGT(outGT), .outEQ(outEQ), .outLT(outLT)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit disturb,
                     output int l, output int bn);
    inA = a;
    inB = b;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    l = -1;
    bn = 0;
    for (int k = 1; k <= 20; k++) begin
      if (disturb && k == 1) begin
        inA = 8'h00;
        inStart = 1'b1;
      end
      bn += int'(outBusy);
      step();
      inStart = 1'b0;
      if (outDone) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    step();
    step();
    chk("reset_outputs", int'({outBusy, outDone, outGT, outEQ, outLT}), 0);
    reset = 1'b0;
    step();
    chk("idle_after_reset", int'({outBusy, outDone, outGT, outEQ, outLT}), 0);

    run(8'hA5, 8'hA5, 1'b0, lat, busy_n);
    chk("eq_latency", lat, 4);
    chk("eq_busy_cycles", busy_n, 4);
    chk("eq_result", int'({outGT, outEQ, outLT}), 3'b010);
    step();
    chk("eq_done_one_cycle", int'({outBusy, outDone}), 0);
    chk("eq_hold_in_idle", int'({outGT, outEQ, outLT}), 3'b010);

    run(8'h80, 8'h7F, 1'b0, lat, busy_n);
    chk("gt_msb_latency", lat, EE ? 1 : 4);
    chk("gt_msb_result", int'({outGT, outEQ, outLT}), 3'b100);
    step();

    run(8'h12, 8'h13, 1'b0, lat, busy_n);
    chk("lt_lsb_latency", lat, 4);
    chk("lt_lsb_result", int'({outGT, outEQ, outLT}), 3'b001);
    step();

    run(8'h00, 8'hFF, 1'b0, lat, busy_n);
    chk("lt_msb_latency", lat, EE ? 1 : 4);
    chk("lt_msb_result", int'({outGT, outEQ, outLT}), 3'b001);
    step();

    run(8'hFF, 8'h00, 1'b1, lat, busy_n);
    chk("restart_latency", lat, EE ? 1 : 4);
    chk("restart_result", int'({outGT, outEQ, outLT}), 3'b100);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen += int'(outBusy) + int'(outDone);
    end
    chk("restart_not_queued", seen, 0);

    inA = 8'hA5;
    inB = 8'hA6;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midbusy_reset_outputs", int'({outBusy, outDone, outGT, outEQ, outLT}), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen += int'(outBusy) + int'(outDone);
    end
    chk("midbusy_reset_no_done", seen, 0);
    run(8'h03, 8'h02, 1'b0, lat, busy_n);
    chk("post_reset_latency", lat, 4);
    chk("post_reset_result", int'({outGT, outEQ, outLT}), 3'b100);
    step();
    step();

    inA = 8'h30;
    inB = 8'h31;
    inStart = 1'b1;
    pulses = 0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outDone) begin
        pulses++;
        idx.push_back(i);
      end
      if (pulses > 0 && {outGT, outEQ, outLT} != 3'b001) stable = 1'b0;
    end
    inStart = 1'b0;
    chk("held_start_pulses", pulses, 3);
    chk("held_start_first", idx.size() > 0 ? idx[0] : -1, 4);
    chk("held_start_period", idx.size() > 2 ? idx[2] - idx[1] : -1, 6);
    chk("held_start_stable", int'(stable), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
